cnn_layer_accel_awe_rb_monitor: RTL and testbench
=================================================

# cnn_layer_accel_awe_rb_monitor

Synthesizable scoreboard for one AWE's row-buffer outputs in the CNN layer accelerator. It snoops the two convolution-engine (CE) output channels of `cnn_layer_accel_awe_rowbuffers`. It recomputes the expected 3x3-style sliding-window sequence for a configured layer and flags any mismatch in row, column, window cycle or last-kernel marking. One instance per AWE sits alongside the quad in scenario-0 benches; it feeds the sc0 environment's error counters.

## Interface
- `PIXEL_WIDTH`, 16, bits per pixel.
- `NUM_CE_PER_AWE`, 2, lanes per dataout word; dataout width `DW = NUM_CE_PER_AWE*PIXEL_WIDTH`.
- `RC_W`, 10, row/column index width (supports 512x512 inputs).
- `CYC_W`, 4, window cycle-counter width.
- `clk`  in  1  core clock (`clk_core` domain). One clock; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_start`  in  1  pulse; latches `cfg_*` and restarts checking.
- `cfg_num_rows`, `cfg_num_cols`  in  `RC_W` each  input map size.
- `cfg_num_kernels`  in  8  kernels per window position (1..255).
- `cfg_kernel_size`  in  3  K (1..3).
- `ce0_pixel_dataout`, `ce1_pixel_dataout`  in  DW each  window pixel lanes.
- `ce0_pixel_dataout_valid`, `ce1_pixel_dataout_valid`  in  1 each  beat qualifiers.
- `output_row_ce0`, `output_row_ce1`, `output_col_ce0`, `output_col_ce1`  in  `RC_W` each  reported output position.
- `ce0_last_kernel`, `ce1_last_kernel`  in  1 each  last-kernel marker.
- `ce0_cycle_counter`, `ce1_cycle_counter`  in  `CYC_W` each  window cycle index.
- `err_valid`  out  1  one-cycle error pulse.
- `err_ce`  out  1  CE that erred.
- `err_code`  out  3  cause code: 1 row, 2 col, 3 cycle, 4 last_kernel, 5 pixel, 6 overrun.
- `error_count`  out  16  saturating error total.
- `beat_count_ce0`, `beat_count_ce1`  out  32 each  accepted beats.
- `done`  out  1  both CEs have completed all expected beats.

## Operation
- Output grid is R'=R-K+1 rows by C'=C-K+1 columns (stride 1, no padding). CE0 owns even output rows starting at 0; CE1 owns odd rows starting at 1.
- Each CE has an independent expected-state tracker (row, col, kernel, cycle). On `cfg_start`: CE0 row is 0, CE1 row is 1, col/kernel/cycle are 0. A CE whose start row is at or beyond R' is immediately finished.
- On each valid beat the tracker compares row, col, cycle (expected 0..K*K-1) and last_kernel (expected 1 iff kernel==num_kernels-1).
- After comparing, the tracker advances: cycle++. Past K*K-1, cycle wraps to 0 and kernel++. Past the last kernel, kernel wraps and col++. Past C'-1, col wraps and row+=2. At row≥R' the CE is finished.
- A valid beat on a finished CE is an overrun (code 6); it is counted but does not advance state.
- Only the first mismatch of a beat is reported, with priority row>col>cycle>last_kernel>pixel. The tracker advances from expected state regardless of observed values (no resync).
- Simultaneous errors on both CEs in one cycle: report CE0 in that cycle, CE1 in the next cycle (one-deep holding register), and count both. If the holding register is already full, the extra error is counted only.
- `error_count` saturates at 0xFFFF. `done` = both CEs finished and holding register empty.

## Timing
- Inputs are registered once; `err_valid`/`err_ce`/`err_code` assert 2 cycles after the offending beat, for 1 cycle.
- `beat_count_*` update 1 cycle after a valid beat.
- `cfg_start` mid-operation: abandons in-flight checks and clears counters, holding register and `done` on the next edge. A beat in the same cycle as `cfg_start` is ignored.
- Reset values: all outputs 0, trackers idle-finished. `done` is 0 until the first `cfg_start` completes.

## Configuration
- `AWE_RB_MON_PIXEL_CHECK_EN`: when defined, each lane j of dataout is checked against the expected input-pattern value {r[7:0],c[7:0]} XOR j. Here r = row + cycle/K and c = col + cycle%K; the tracker maintains wrow/wcol sub-counters and performs no division. A mismatch reports code 5.
- When undefined, pixel data is ignored and code 5 never occurs.

## Structure
- Shared package `cnn_layer_accel_verif_pkg` holds the error-code enum and the default widths `PIXEL_WIDTH`, `NUM_CE_PER_AWE` and `RC_W`.
- One sub-module, `awe_rb_ce_tracker`, instantiated twice (start row 0 / 1). It holds the expected-state counters, the compare logic and the per-CE beat counter. The top level holds arbitration, the holding register, `error_count` and `done`.

## Test plan
- R=C=5, K=3, kernels=1, perfect stream: 9 CE0 beats ×3 columns for rows 0 and 2; CE1 row 1 → error_count=0, done=1, beat_count_ce0=54, beat_count_ce1=27.
- Same config with CE0 beat #10 reporting col=2 instead of 1 → single err_valid, err_ce=0, err_code=2, error_count=1.
- kernels=5 with last_kernel asserted on kernel 3 → err_code=4 on that beat, and again on kernel 4 (missing marker); error_count=2.
- Extra CE1 beat after completion → err_code=6, beat_count_ce1 unchanged.
- Both CEs err in the same cycle → CE0 report then CE1 report on consecutive cycles; error_count=2.
- With the macro defined, flip lane 1 bit 0 on one beat → err_code=5; without the macro, the same stimulus gives error_count=0.

Source files
------------

// File: rtl/cnn_layer_accel_verif_pkg.sv
// +------------------------------------------------------------------+
// | cnn_layer_accel_verif_pkg                                        |
// | Shared error codes, default widths and the pixel pattern helper. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package cnn_layer_accel_verif_pkg;

    localparam int DEF_PIXEL_WIDTH    = 16;
    localparam int DEF_NUM_CE_PER_AWE = 2;
    localparam int DEF_RC_W           = 10;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ROW         = 3'd1,
        ERR_COL         = 3'd2,
        ERR_CYCLE       = 3'd3,
        ERR_LAST_KERNEL = 3'd4,
        ERR_PIXEL       = 3'd5,
        ERR_OVERRUN     = 3'd6
    } err_code_e;

    function automatic logic [15:0] awe_rb_pattern(input logic [7:0] r, input logic [7:0] c);
        return {r, c};
    endfunction

endpackage

`default_nettype wire

// File: rtl/awe_rb_ce_tracker.sv
// +------------------------------------------------------------------+
// | awe_rb_ce_tracker                                                |
// | Expected-state tracker, compare and beat counter for one CE.     |
// | Pixel compare enabled by AWE_RB_MON_PIXEL_CHECK_EN.              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module awe_rb_ce_tracker
    import cnn_layer_accel_verif_pkg::*;
#(
    parameter int PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
    parameter int NUM_CE_PER_AWE = DEF_NUM_CE_PER_AWE,
    parameter int RC_W           = DEF_RC_W,
    parameter int CYC_W          = 4,
    parameter int START_ROW      = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_start,
    input  logic [RC_W-1:0]                       out_rows,
    input  logic [RC_W-1:0]                       out_cols,
    input  logic [1:0]                            k_last,
    input  logic [CYC_W-1:0]                      kk_last,
    input  logic [7:0]                            nk_last,
    input  logic                                  in_valid,
    input  logic [RC_W-1:0]                       in_row,
    input  logic [RC_W-1:0]                       in_col,
    input  logic                                  in_last,
    input  logic [CYC_W-1:0]                      in_cyc,
    input  logic [NUM_CE_PER_AWE*PIXEL_WIDTH-1:0] in_data,
    output logic [31:0]                           beat_count,
    output logic                                  err,
    output err_code_e                             err_code,
    output logic                                  finished
);

    localparam logic [RC_W-1:0] START_ROW_V = RC_W'(START_ROW);

    logic              v_q, v_d;
    logic [RC_W-1:0]   row_in_q, row_in_d, col_in_q, col_in_d;
    logic              last_in_q, last_in_d;
    logic [CYC_W-1:0]  cyc_in_q, cyc_in_d;
    logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
    logic [7:0]        kern_q, kern_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [1:0]        wrow_q, wrow_d, wcol_q, wcol_d;
    logic              fin_q, fin_d;
    logic [31:0]       beat_count_q, beat_count_d;
    logic [RC_W:0]     row_sum;
    logic              pix_bad;

`ifdef AWE_RB_MON_PIXEL_CHECK_EN
    logic [NUM_CE_PER_AWE*PIXEL_WIDTH-1:0] data_q;
    logic [7:0] r8, c8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_q <= '0;
        else     data_q <= in_data;
    end

    // Window pixel origin is tracked by wrow/wcol so no division is needed.
    always_comb begin
        pix_bad = 1'b0;
        r8 = row_q[7:0] + {6'b0, wrow_q};
        c8 = col_q[7:0] + {6'b0, wcol_q};
        for (int j = 0; j < NUM_CE_PER_AWE; j++) begin
            if (data_q[j*PIXEL_WIDTH +: PIXEL_WIDTH] !=
                (PIXEL_WIDTH'(awe_rb_pattern(r8, c8)) ^ PIXEL_WIDTH'(j)))
                pix_bad = 1'b1;
        end
    end
`else
    logic unused_data;
    assign unused_data = ^in_data;
    assign pix_bad     = 1'b0;
`endif

    assign row_sum = {1'b0, row_q} + (RC_W+1)'(2);

    always_comb begin
        v_d       = in_valid & ~cfg_start;
        row_in_d  = in_row;
        col_in_d  = in_col;
        last_in_d = in_last;
        cyc_in_d  = in_cyc;
        row_d     = row_q;
        col_d     = col_q;
        kern_d    = kern_q;
        cyc_d     = cyc_q;
        wrow_d    = wrow_q;
        wcol_d    = wcol_q;
        fin_d     = fin_q;
        err       = 1'b0;
        err_code  = ERR_NONE;

        if (cfg_start) begin
            row_d  = START_ROW_V;
            col_d  = '0;
            kern_d = '0;
            cyc_d  = '0;
            wrow_d = '0;
            wcol_d = '0;
            fin_d  = (START_ROW_V >= out_rows) || (out_cols == '0);
        end else if (v_q && fin_q) begin
            err      = 1'b1;
            err_code = ERR_OVERRUN;
        end else if (v_q) begin
            err = 1'b1;
            if      (row_in_q != row_q)                  err_code = ERR_ROW;
            else if (col_in_q != col_q)                  err_code = ERR_COL;
            else if (cyc_in_q != cyc_q)                  err_code = ERR_CYCLE;
            else if (last_in_q != (kern_q == nk_last))   err_code = ERR_LAST_KERNEL;
            else if (pix_bad)                            err_code = ERR_PIXEL;
            else                                         err      = 1'b0;

            // Advance from the expected state; observed values never resync it.
            if (cyc_q == kk_last) begin
                cyc_d  = '0;
                wrow_d = '0;
                wcol_d = '0;
                if (kern_q == nk_last) begin
                    kern_d = '0;
                    if (col_q == out_cols - RC_W'(1)) begin
                        col_d = '0;
                        row_d = row_sum[RC_W-1:0];
                        if (row_sum >= {1'b0, out_rows}) fin_d = 1'b1;
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                end else begin
                    kern_d = kern_q + 8'd1;
                end
            end else begin
                cyc_d = cyc_q + CYC_W'(1);
                if (wcol_q == k_last) begin
                    wcol_d = '0;
                    wrow_d = wrow_q + 2'd1;
                end else begin
                    wcol_d = wcol_q + 2'd1;
                end
            end
        end

        // A raw beat is accepted if the tracker will not be finished when it arrives.
        if (cfg_start)               beat_count_d = '0;
        else if (in_valid && !fin_d) beat_count_d = beat_count_q + 32'd1;
        else                         beat_count_d = beat_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q          <= 1'b0;
            row_in_q     <= '0;
            col_in_q     <= '0;
            last_in_q    <= 1'b0;
            cyc_in_q     <= '0;
            row_q        <= START_ROW_V;
            col_q        <= '0;
            kern_q       <= '0;
            cyc_q        <= '0;
            wrow_q       <= '0;
            wcol_q       <= '0;
            fin_q        <= 1'b1;
            beat_count_q <= '0;
        end else begin
            v_q          <= v_d;
            row_in_q     <= row_in_d;
            col_in_q     <= col_in_d;
            last_in_q    <= last_in_d;
            cyc_in_q     <= cyc_in_d;
            row_q        <= row_d;
            col_q        <= col_d;
            kern_q       <= kern_d;
            cyc_q        <= cyc_d;
            wrow_q       <= wrow_d;
            wcol_q       <= wcol_d;
            fin_q        <= fin_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;
    assign finished   = fin_q;

endmodule

`default_nettype wire

// File: rtl/cnn_layer_accel_awe_rb_monitor.sv
// +------------------------------------------------------------------+
// | cnn_layer_accel_awe_rb_monitor                                   |
// | Row-buffer output scoreboard for one AWE: two CE trackers, error |
// | arbitration with a one-deep holding register, error counter.     |
// | Optional pixel check: AWE_RB_MON_PIXEL_CHECK_EN.                 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module cnn_layer_accel_awe_rb_monitor
    import cnn_layer_accel_verif_pkg::*;
#(
    parameter int PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
    parameter int NUM_CE_PER_AWE = DEF_NUM_CE_PER_AWE,
    parameter int RC_W           = DEF_RC_W,
    parameter int CYC_W          = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_start,
    input  logic [RC_W-1:0]                       cfg_num_rows,
    input  logic [RC_W-1:0]                       cfg_num_cols,
    input  logic [7:0]                            cfg_num_kernels,
    input  logic [2:0]                            cfg_kernel_size,
    input  logic [NUM_CE_PER_AWE*PIXEL_WIDTH-1:0] ce0_pixel_dataout,
    input  logic [NUM_CE_PER_AWE*PIXEL_WIDTH-1:0] ce1_pixel_dataout,
    input  logic                                  ce0_pixel_dataout_valid,
    input  logic                                  ce1_pixel_dataout_valid,
    input  logic [RC_W-1:0]                       output_row_ce0,
    input  logic [RC_W-1:0]                       output_row_ce1,
    input  logic [RC_W-1:0]                       output_col_ce0,
    input  logic [RC_W-1:0]                       output_col_ce1,
    input  logic                                  ce0_last_kernel,
    input  logic                                  ce1_last_kernel,
    input  logic [CYC_W-1:0]                      ce0_cycle_counter,
    input  logic [CYC_W-1:0]                      ce1_cycle_counter,
    output logic                                  err_valid,
    output logic                                  err_ce,
    output logic [2:0]                            err_code,
    output logic [15:0]                           error_count,
    output logic [31:0]                           beat_count_ce0,
    output logic [31:0]                           beat_count_ce1,
    output logic                                  done
);

    logic [RC_W-1:0]  rows_q, rows_d, cols_q, cols_d, rows_raw, cols_raw, k_rc;
    logic [1:0]       klast_q, klast_d;
    logic [CYC_W-1:0] kklast_q, kklast_d;
    logic [7:0]       nklast_q, nklast_d;
    logic [5:0]       kk_raw;
    logic             e0, e1, fin0, fin1;
    err_code_e        c0, c1;
    logic             err_valid_q, err_valid_d, err_ce_q, err_ce_d;
    err_code_e        err_code_q, err_code_d, hold_code_q, hold_code_d;
    logic             hold_v_q, hold_v_d, hold_ce_q, hold_ce_d;
    logic [15:0]      error_count_q, error_count_d;
    logic [16:0]      cnt_sum;
    logic             done_q, done_d, started_q, started_d;

    assign k_rc     = RC_W'(cfg_kernel_size);
    assign rows_raw = (cfg_num_rows >= k_rc) ? cfg_num_rows - k_rc + RC_W'(1) : '0;
    assign cols_raw = (cfg_num_cols >= k_rc) ? cfg_num_cols - k_rc + RC_W'(1) : '0;
    assign kk_raw   = {3'b0, cfg_kernel_size} * {3'b0, cfg_kernel_size};

    // Trackers see the new configuration in the cfg_start cycle itself.
    always_comb begin
        rows_d   = cfg_start ? rows_raw : rows_q;
        cols_d   = cfg_start ? cols_raw : cols_q;
        klast_d  = cfg_start ? 2'(cfg_kernel_size - 3'd1) : klast_q;
        kklast_d = cfg_start ? CYC_W'(kk_raw - 6'd1) : kklast_q;
        nklast_d = cfg_start ? cfg_num_kernels - 8'd1 : nklast_q;
    end

    awe_rb_ce_tracker #(
        .PIXEL_WIDTH(PIXEL_WIDTH), .NUM_CE_PER_AWE(NUM_CE_PER_AWE),
        .RC_W(RC_W), .CYC_W(CYC_W), .START_ROW(0)
    ) u_trk_ce0 (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .out_rows(rows_d), .out_cols(cols_d), .k_last(klast_d),
        .kk_last(kklast_d), .nk_last(nklast_d),
        .in_valid(ce0_pixel_dataout_valid), .in_row(output_row_ce0),
        .in_col(output_col_ce0), .in_last(ce0_last_kernel),
        .in_cyc(ce0_cycle_counter), .in_data(ce0_pixel_dataout),
        .beat_count(beat_count_ce0), .err(e0), .err_code(c0), .finished(fin0)
    );

    awe_rb_ce_tracker #(
        .PIXEL_WIDTH(PIXEL_WIDTH), .NUM_CE_PER_AWE(NUM_CE_PER_AWE),
        .RC_W(RC_W), .CYC_W(CYC_W), .START_ROW(1)
    ) u_trk_ce1 (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .out_rows(rows_d), .out_cols(cols_d), .k_last(klast_d),
        .kk_last(kklast_d), .nk_last(nklast_d),
        .in_valid(ce1_pixel_dataout_valid), .in_row(output_row_ce1),
        .in_col(output_col_ce1), .in_last(ce1_last_kernel),
        .in_cyc(ce1_cycle_counter), .in_data(ce1_pixel_dataout),
        .beat_count(beat_count_ce1), .err(e1), .err_code(c1), .finished(fin1)
    );

    assign cnt_sum = {1'b0, error_count_q} + 17'(e0) + 17'(e1);

    always_comb begin
        err_valid_d   = 1'b0;
        err_ce_d      = 1'b0;
        err_code_d    = ERR_NONE;
        hold_v_d      = 1'b0;
        hold_ce_d     = hold_ce_q;
        hold_code_d   = hold_code_q;
        error_count_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        started_d     = started_q | cfg_start;

        // Oldest first: held error, then CE0, then CE1; a third is counted only.
        if (hold_v_q) begin
            err_valid_d = 1'b1;
            err_ce_d    = hold_ce_q;
            err_code_d  = hold_code_q;
            if (e0) begin
                hold_v_d = 1'b1; hold_ce_d = 1'b0; hold_code_d = c0;
            end else if (e1) begin
                hold_v_d = 1'b1; hold_ce_d = 1'b1; hold_code_d = c1;
            end
        end else if (e0) begin
            err_valid_d = 1'b1;
            err_code_d  = c0;
            if (e1) begin
                hold_v_d = 1'b1; hold_ce_d = 1'b1; hold_code_d = c1;
            end
        end else if (e1) begin
            err_valid_d = 1'b1;
            err_ce_d    = 1'b1;
            err_code_d  = c1;
        end

        done_d = started_q & fin0 & fin1 & ~hold_v_d;

        if (cfg_start) begin
            err_valid_d   = 1'b0;
            err_ce_d      = 1'b0;
            err_code_d    = ERR_NONE;
            hold_v_d      = 1'b0;
            error_count_d = '0;
            done_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q        <= '0;
            cols_q        <= '0;
            klast_q       <= '0;
            kklast_q      <= '0;
            nklast_q      <= '0;
            err_valid_q   <= 1'b0;
            err_ce_q      <= 1'b0;
            err_code_q    <= ERR_NONE;
            hold_v_q      <= 1'b0;
            hold_ce_q     <= 1'b0;
            hold_code_q   <= ERR_NONE;
            error_count_q <= '0;
            done_q        <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            klast_q       <= klast_d;
            kklast_q      <= kklast_d;
            nklast_q      <= nklast_d;
            err_valid_q   <= err_valid_d;
            err_ce_q      <= err_ce_d;
            err_code_q    <= err_code_d;
            hold_v_q      <= hold_v_d;
            hold_ce_q     <= hold_ce_d;
            hold_code_q   <= hold_code_d;
            error_count_q <= error_count_d;
            done_q        <= done_d;
            started_q     <= started_d;
        end
    end

    assign err_valid   = err_valid_q;
    assign err_ce      = err_ce_q;
    assign err_code    = err_code_q;
    assign error_count = error_count_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_layer_accel_awe_rb_monitor.sv
// +------------------------------------------------------------------+
// | tb_cnn_layer_accel_awe_rb_monitor                                |
// | Directed bench for the AWE row-buffer monitor (5x5 map, K=3).    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_cnn_layer_accel_awe_rb_monitor;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic [9:0]    cfg_num_rows = '0, cfg_num_cols = '0;
    logic [7:0]    cfg_num_kernels = '0;
    logic [2:0]    cfg_kernel_size = '0;
    logic [DW-1:0] ce0_pixel_dataout = '0, ce1_pixel_dataout = '0;
    logic          ce0_pixel_dataout_valid = 1'b0, ce1_pixel_dataout_valid = 1'b0;
    logic [9:0]    output_row_ce0 = '0, output_row_ce1 = '0;
    logic [9:0]    output_col_ce0 = '0, output_col_ce1 = '0;
    logic          ce0_last_kernel = 1'b0, ce1_last_kernel = 1'b0;
    logic [3:0]    ce0_cycle_counter = '0, ce1_cycle_counter = '0;
    logic          err_valid, err_ce, done;
    logic [2:0]    err_code;
    logic [15:0]   error_count;
    logic [31:0]   beat_count_ce0, beat_count_ce1;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int fault_cyc = 0;

    typedef struct {int ce; int code; int cyc;} ev_t;
    ev_t evq[$];

    cnn_layer_accel_awe_rb_monitor dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_num_rows(cfg_num_rows), .cfg_num_cols(cfg_num_cols),
        .cfg_num_kernels(cfg_num_kernels), .cfg_kernel_size(cfg_kernel_size),
        .ce0_pixel_dataout(ce0_pixel_dataout), .ce1_pixel_dataout(ce1_pixel_dataout),
        .ce0_pixel_dataout_valid(ce0_pixel_dataout_valid),
        .ce1_pixel_dataout_valid(ce1_pixel_dataout_valid),
        .output_row_ce0(output_row_ce0), .output_row_ce1(output_row_ce1),
        .output_col_ce0(output_col_ce0), .output_col_ce1(output_col_ce1),
        .ce0_last_kernel(ce0_last_kernel), .ce1_last_kernel(ce1_last_kernel),
        .ce0_cycle_counter(ce0_cycle_counter), .ce1_cycle_counter(ce1_cycle_counter),
        .err_valid(err_valid), .err_ce(err_ce), .err_code(err_code),
        .error_count(error_count), .beat_count_ce0(beat_count_ce0),
        .beat_count_ce1(beat_count_ce1), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (err_valid === 1'b1) evq.push_back('{int'(err_ce), int'(err_code), cyc_cnt});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ev_ce(input int i);
        return (i < evq.size()) ? evq[i].ce : -1;
    endfunction
    function automatic int ev_code(input int i);
        return (i < evq.size()) ? evq[i].code : -1;
    endfunction
    function automatic int ev_cyc(input int i);
        return (i < evq.size()) ? evq[i].cyc : -1;
    endfunction

    // kind: 0 clean, 1 col+1, 2 invert last_kernel, 3 flip lane1 bit0
    task automatic drive_ce(input int ce, input int i, input int s, input int nk, input int kind);
        int cyc, kern, pos, col, row, r, c;
        logic [15:0] p;
        logic [DW-1:0] d;
        logic lk;
        cyc  = i % 9;
        kern = (i / 9) % nk;
        pos  = i / (9 * nk);
        col  = pos % 3;
        row  = s + 2 * (pos / 3);
        r    = row + cyc / 3;
        c    = col + cyc % 3;
        p    = {8'(r), 8'(c)};
        d    = {p ^ 16'd1, p};
        lk   = (kern == nk - 1);
        case (kind)
            1: col = col + 1;
            2: lk = ~lk;
            3: d[16] = ~d[16];
            default: ;
        endcase
        if (ce == 0) begin
            ce0_pixel_dataout = d; ce0_pixel_dataout_valid = 1'b1;
            output_row_ce0 = 10'(row); output_col_ce0 = 10'(col);
            ce0_last_kernel = lk; ce0_cycle_counter = 4'(cyc);
        end else begin
            ce1_pixel_dataout = d; ce1_pixel_dataout_valid = 1'b1;
            output_row_ce1 = 10'(row); output_col_ce1 = 10'(col);
            ce1_last_kernel = lk; ce1_cycle_counter = 4'(cyc);
        end
    endtask

    task automatic do_cfg(input int nk);
        @(posedge clk); #1;
        cfg_num_rows = 10'd5; cfg_num_cols = 10'd5;
        cfg_num_kernels = 8'(nk); cfg_kernel_size = 3'd3;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        evq.delete();
    endtask

    task automatic run_stream(input int nk, input int f0a, input int k0a,
                              input int f0b, input int k0b, input int f1, input int k1);
        int n0, n1;
        n0 = 2 * 3 * nk * 9;
        n1 = 3 * nk * 9;
        for (int i = 0; i < n0; i++) begin
            @(posedge clk); #1;
            drive_ce(0, i, 0, nk, (i == f0a) ? k0a : ((i == f0b) ? k0b : 0));
            if (i == f0a) fault_cyc = cyc_cnt;
            if (i < n1) drive_ce(1, i, 1, nk, (i == f1) ? k1 : 0);
            else ce1_pixel_dataout_valid = 1'b0;
        end
        @(posedge clk); #1;
        ce0_pixel_dataout_valid = 1'b0;
        ce1_pixel_dataout_valid = 1'b0;
        for (int w = 0; w < 40 && done !== 1'b1; w++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_err_valid", 32'(err_valid), 0);
        check("rst_error_count", 32'(error_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_beat_ce0", beat_count_ce0, 0);
        check("rst_beat_ce1", beat_count_ce1, 0);

        // Clean stream, one kernel
        do_cfg(1);
        check("cfg_done_clear", 32'(done), 0);
        run_stream(1, -1, 0, -1, 0, -1, 0);
        check("clean_error_count", 32'(error_count), 0);
        check("clean_events", 32'(evq.size()), 0);
        check("clean_done", 32'(done), 1);
        check("clean_beat_ce0", beat_count_ce0, 54);
        check("clean_beat_ce1", beat_count_ce1, 27);

        // CE0 beat #10 reports col 2 instead of 1
        do_cfg(1);
        check("restart_beat_ce0", beat_count_ce0, 0);
        check("restart_error_count", 32'(error_count), 0);
        run_stream(1, 9, 1, -1, 0, -1, 0);
        check("col_events", 32'(evq.size()), 1);
        check("col_err_ce", 32'(ev_ce(0)), 0);
        check("col_err_code", 32'(ev_code(0)), 2);
        check("col_latency", 32'(ev_cyc(0) - fault_cyc), 2);
        check("col_error_count", 32'(error_count), 1);
        check("col_done", 32'(done), 1);

        // Five kernels: spurious marker on kernel 3, missing marker on kernel 4
        do_cfg(5);
        run_stream(5, 27, 2, 36, 2, -1, 0);
        check("lk_events", 32'(evq.size()), 2);
        check("lk_code0", 32'(ev_code(0)), 4);
        check("lk_code1", 32'(ev_code(1)), 4);
        check("lk_error_count", 32'(error_count), 2);
        check("lk_beat_ce0", beat_count_ce0, 270);
        check("lk_beat_ce1", beat_count_ce1, 135);

        // Extra CE1 beat after completion
        evq.delete();
        @(posedge clk); #1;
        drive_ce(1, 0, 1, 5, 0);
        @(posedge clk); #1;
        ce1_pixel_dataout_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ovr_events", 32'(evq.size()), 1);
        check("ovr_err_ce", 32'(ev_ce(0)), 1);
        check("ovr_err_code", 32'(ev_code(0)), 6);
        check("ovr_beat_ce1", beat_count_ce1, 135);
        check("ovr_error_count", 32'(error_count), 3);

        // Both CEs err on the same beat
        do_cfg(1);
        run_stream(1, 5, 2, -1, 0, 5, 1);
        check("dual_events", 32'(evq.size()), 2);
        check("dual_first_ce", 32'(ev_ce(0)), 0);
        check("dual_first_code", 32'(ev_code(0)), 4);
        check("dual_second_ce", 32'(ev_ce(1)), 1);
        check("dual_second_code", 32'(ev_code(1)), 2);
        check("dual_spacing", 32'(ev_cyc(1) - ev_cyc(0)), 1);
        check("dual_error_count", 32'(error_count), 2);
        check("dual_done", 32'(done), 1);

        // Lane 1 bit 0 flipped on one CE1 beat
        do_cfg(1);
        run_stream(1, -1, 0, -1, 0, 3, 3);
`ifdef AWE_RB_MON_PIXEL_CHECK_EN
        check("pix_events", 32'(evq.size()), 1);
        check("pix_err_ce", 32'(ev_ce(0)), 1);
        check("pix_err_code", 32'(ev_code(0)), 5);
        check("pix_error_count", 32'(error_count), 1);
`else
        check("pix_events", 32'(evq.size()), 0);
        check("pix_error_count", 32'(error_count), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
